// File: rtl/param_serial_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first.
// The carry between chunks is held in a register. The signed-overflow flag
// uses the carry into the top bit, which is tracked inside the last chunk.
//
// state | meaning
// IDLE  | waiting for start; s/cout/ovf hold the last result
// RUN   | one chunk processed per clock; busy=1
// DONE  | single-cycle done pulse; start here chains the next operation
module param_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject parameter sets that cannot be split into whole chunks.
    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("param_serial_addsub: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [CHUNK-1:0]  sum_chunk;
    logic              chunk_cout;
    logic              chunk_cin_msb;
    logic              carry_v;

    // Ripple add of the current low chunk of A and B' plus the carry register.
    always_comb begin
        sum_chunk     = '0;
        chunk_cin_msb = 1'b0;
        carry_v       = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                chunk_cin_msb = carry_v;
            end
            sum_chunk[i] = a_q[i] ^ b_q[i] ^ carry_v;
            carry_v      = (a_q[i] & b_q[i]) | (carry_v & (a_q[i] ^ b_q[i]));
        end
        chunk_cout = carry_v;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = (res_q >> CHUNK) | (WIDTH'(sum_chunk) << (WIDTH - CHUNK));
                carry_d = chunk_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = res_d;
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_cout ^ chunk_cin_msb;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture is shared by IDLE and DONE so back-to-back operations need no gap.
        if (state_q != RUN && start) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = cin ^ sub;
            cnt_d   = '0;
            res_d   = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_param_serial_addsub.sv
// Bench for param_serial_addsub: three configurations (8/2, 2/1, 8/8),
// expected results queued at start and compared when done pulses.
module tb_param_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared operand bus for the two 8-bit instances
    logic [7:0] a8 = '0, b8 = '0;
    logic       sub8 = 1'b0, cin8 = 1'b0;
    logic       start0 = 1'b0, start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       sub2 = 1'b0, cin2 = 1'b0, start1 = 1'b0;

    logic       busy0, done0, cout0, ovf0;
    logic [7:0] s0;
    logic       busy1, done1, cout1, ovf1;
    logic [1:0] s1;
    logic       busy2, done2, cout2, ovf2;
    logic [7:0] s2;

    param_serial_addsub #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy0), .done(done0), .s(s0), .cout(cout0), .ovf(ovf0));

    param_serial_addsub #(.WIDTH(2), .CHUNK(1)) u_w2c1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));

    param_serial_addsub #(.WIDTH(8), .CHUNK(8)) u_w8c8 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy2), .done(done2), .s(s2), .cout(cout2), .ovf(ovf2));

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {s[7:0], cout, ovf} from integer arithmetic on unsigned/signed views.
    function automatic logic [9:0] mdl(input int w, input int a, input int b, input int cin, input int sub);
        int m, half, sa, sb, r, u;
        logic [7:0] sv;
        logic co, ov;
        m    = 1 << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (sub != 0) begin
            r  = sa - sb - cin;
            u  = a - b - cin;
            co = (u >= 0);
        end else begin
            r  = sa + sb + cin;
            u  = a + b + cin;
            co = (u >= m);
        end
        ov = (r >= half) || (r < -half);
        sv = 8'((u + 2 * m) % m);
        return {sv, co, ov};
    endfunction

    function automatic logic dn(input int id);
        return (id == 0) ? done0 : (id == 1) ? done1 : done2;
    endfunction

    function automatic logic bz(input int id);
        return (id == 0) ? busy0 : (id == 1) ? busy1 : busy2;
    endfunction

    // Output monitors: compare on each done pulse against the queue head.
    always @(negedge clk) begin
        logic [9:0] e;
        if (done0) begin
            chk("busy_with_done0", 32'(busy0), 32'd0);
            if (q0.size() == 0) chk("unexpected_done0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("s0", 32'(s0), 32'(e[9:2]));
                chk("cout0", 32'(cout0), 32'(e[1]));
                chk("ovf0", 32'(ovf0), 32'(e[0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (done1) begin
            chk("busy_with_done1", 32'(busy1), 32'd0);
            if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("s1", 32'(s1), 32'(e[9:2]));
                chk("cout1", 32'(cout1), 32'(e[1]));
                chk("ovf1", 32'(ovf1), 32'(e[0]));
            end
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (done2) begin
            chk("busy_with_done2", 32'(busy2), 32'd0);
            if (q2.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                chk("s2", 32'(s2), 32'(e[9:2]));
                chk("cout2", 32'(cout2), 32'(e[1]));
                chk("ovf2", 32'(ovf2), 32'(e[0]));
            end
        end
    end

    // Count negedges until done; checks latency (edges after start) and busy length.
    task automatic wait_done(input int id, input int lat_exp);
        int  k    = 0;
        int  nb   = 0;
        bit  seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (dn(id)) seen = 1;
            else if (bz(id)) nb++;
        end
        chk($sformatf("latency%0d", id), 32'(k - 1), 32'(lat_exp));
        chk($sformatf("busy_len%0d", id), 32'(nb), 32'(lat_exp));
    endtask

    // Issue one operation; returns #1 after the start edge, or at the done negedge if waiting.
    task automatic run(input int id, input int a, input int b, input int cin, input int sub,
                       input bit wait_it, input int lat_exp);
        if (id == 1) begin
            a2 = 2'(a); b2 = 2'(b); cin2 = 1'(cin); sub2 = 1'(sub); start1 = 1'b1;
            q1.push_back(mdl(2, a, b, cin, sub));
        end else begin
            a8 = 8'(a); b8 = 8'(b); cin8 = 1'(cin); sub8 = 1'(sub);
            if (id == 0) begin
                start0 = 1'b1;
                q0.push_back(mdl(8, a, b, cin, sub));
            end else begin
                start2 = 1'b1;
                q2.push_back(mdl(8, a, b, cin, sub));
            end
        end
        @(posedge clk) #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        if (wait_it) wait_done(id, lat_exp);
    endtask

    task automatic step();
        @(posedge clk) #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_s", 32'(s0), 32'd0);
        chk("rst_cout", 32'(cout0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        rst_n = 1'b1;
        step();

        // basic add, wraps, subtracts
        run(0, 'h3C, 'h45, 0, 0, 1, 4); step();
        run(0, 'hFF, 'h01, 0, 0, 1, 4); step();
        run(0, 'h7F, 'h00, 1, 0, 1, 4); step();
        run(0, 'h10, 'h20, 0, 1, 1, 4); step();
        run(0, 'h80, 'h01, 0, 1, 1, 4); step();
        run(0, 'h33, 'h11, 1, 1, 1, 4); step();

        // result holds across idle cycles (last was 0x33-0x11-1 = 0x21)
        repeat (5) @(negedge clk);
        chk("hold_s0", 32'(s0), 32'h21);
        step();

        // start pulse mid-run with other operands is ignored
        run(0, 'h12, 'h34, 0, 0, 0, 0);
        a8 = 8'hAA; b8 = 8'hCC; sub8 = 1'b1; start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_done(0, 3);
        step();
        repeat (6) @(negedge clk);
        step();

        // back-to-back: start held during DONE
        run(0, 'h5A, 'h3C, 0, 0, 1, 4);
        run(0, 'hC8, 'h64, 1, 1, 1, 4);
        step();

        // random mix
        for (int i = 0; i < 8; i++) begin
            run(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1, 4);
            step();
        end

        // asynchronous reset in the middle of RUN
        run(0, 'h55, 'h22, 0, 0, 0, 0);
        @(posedge clk) #2;
        rst_n = 1'b0;
        #1;
        chk("rstrun_busy", 32'(busy0), 32'd0);
        chk("rstrun_done", 32'(done0), 32'd0);
        chk("rstrun_s", 32'(s0), 32'd0);
        q0.delete();
        #10 rst_n = 1'b1;
        step();
        repeat (8) @(negedge clk);
        step();
        run(0, 'h01, 'h01, 0, 0, 1, 4); step();

        // WIDTH=2 CHUNK=1 exhaustive add sweep
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                run(1, x, y, 0, 0, 1, 2); step();
            end
        end

        // WIDTH=8 CHUNK=8: single-cycle operations, including back-to-back
        run(2, 'h3C, 'h45, 0, 0, 1, 1); step();
        run(2, 'h80, 'h01, 0, 1, 1, 1);
        run(2, 'hFF, 'hFF, 1, 0, 1, 1); step();

        repeat (3) @(negedge clk);
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        chk("q2_empty", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
